// File: rtl/risc_pkg.sv
// risc_pkg: opcode and phase encodings shared by the Simple-RISC controller, datapath and bench.
package risc_pkg;
  localparam int PHASE_W = 4;
  localparam int OPC_W = 3;
  localparam logic [OPC_W-1:0] HLT = 3'd0;
  localparam logic [OPC_W-1:0] SKZ = 3'd1;
  localparam logic [OPC_W-1:0] ADD = 3'd2;
  localparam logic [OPC_W-1:0] AND = 3'd3;
  localparam logic [OPC_W-1:0] XOR = 3'd4;
  localparam logic [OPC_W-1:0] LDA = 3'd5;
  localparam logic [OPC_W-1:0] STO = 3'd6;
  localparam logic [OPC_W-1:0] JMP = 3'd7;
  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } phase_e;
  function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
    return opc == ADD || opc == AND || opc == XOR || opc == LDA;
  endfunction
endpackage

// File: rtl/risc_controller.sv
// risc_controller: 8-phase fetch/execute sequencer driving the Simple-RISC datapath strobes.
module risc_controller
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               inc_pc,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_next;
  logic               w_alu;
  logic               w_hlt;
  assign w_alu = is_aluop(opcode);
  assign w_hlt = opcode == HLT;
  assign phase = r_phase;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_phase <= INST_ADDR;
    else      r_phase <= w_next;
  // Unlisted phase codes fall to the defaults: all outputs low, restart at INST_ADDR.
  always_comb begin
    w_next = INST_ADDR;
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (r_phase)
      INST_ADDR: begin
        sel    = 1'b1;
        w_next = INST_FETCH;
      end
      INST_FETCH: begin
        sel    = 1'b1;
        rd     = 1'b1;
        w_next = INST_LOAD;
      end
      INST_LOAD: begin
        sel    = 1'b1;
        rd     = 1'b1;
        ld_ir  = 1'b1;
        w_next = IDLE;
      end
      IDLE: begin
        sel    = 1'b1;
        rd     = 1'b1;
        ld_ir  = 1'b1;
        w_next = OP_ADDR;
      end
      OP_ADDR: begin
        inc_pc = !w_hlt;
        halt   = w_hlt;
        w_next = w_hlt ? HALTED : OP_FETCH;
      end
      OP_FETCH: begin
        rd     = w_alu;
        w_next = ALU_OP;
      end
      ALU_OP: begin
        rd     = w_alu;
        inc_pc = opcode == SKZ && zero;
        ld_pc  = opcode == JMP;
        data_e = opcode == STO;
        w_next = STORE;
      end
      STORE: begin
        rd     = w_alu;
        ld_ac  = w_alu;
        ld_pc  = opcode == JMP;
        wr     = opcode == STO;
        data_e = opcode == STO;
        w_next = INST_ADDR;
      end
      HALTED: begin
        halt   = 1'b1;
        w_next = HALTED;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed per-instruction checks of phase sequence and strobe decode.
module tb_risc_controller;
  import risc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic zero = 1'b0;
  logic [OPC_W-1:0] opcode = LDA;
  logic sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [PHASE_W-1:0] phase;
  logic [8:0] outs;
  int checks = 0;
  int errors = 0;
  assign outs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
  always #5 clk = ~clk;
  risc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );
  // outs bit order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
  task automatic test_reset();
    rst = 1'b0;
    opcode = LDA;
    repeat (2) @(negedge clk);
    checks++;
    if (phase !== 4'd0 || outs !== 9'h100) begin
      errors++;
      $display("FAIL reset_hold phase=%0d outs=%h required phase=0 outs=100", phase, outs);
    end
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (phase !== PHASE_W'(i % 8)) begin
        errors++;
        $display("FAIL reset_seq step%0d phase=%0d required %0d", i, phase, i % 8);
      end
    end
  endtask
  task automatic test_lda();
    logic [7:0][8:0] e;
    e = {9'h090, 9'h080, 9'h080, 9'h004, 9'h1A0, 9'h1A0, 9'h180, 9'h100};
    opcode = LDA;
    zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (phase !== PHASE_W'(p) || outs !== e[p]) begin
        errors++;
        $display("FAIL lda p%0d phase=%0d outs=%h required phase=%0d outs=%h", p, phase, outs, p, e[p]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_sto();
    logic [7:0][8:0] e;
    e = {9'h042, 9'h002, 9'h000, 9'h004, 9'h1A0, 9'h1A0, 9'h180, 9'h100};
    opcode = STO;
    zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (phase !== PHASE_W'(p) || outs !== e[p]) begin
        errors++;
        $display("FAIL sto p%0d phase=%0d outs=%h required phase=%0d outs=%h", p, phase, outs, p, e[p]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_skz(input logic z);
    logic [7:0][8:0] e;
    e = {9'h000, z ? 9'h004 : 9'h000, 9'h000, 9'h004, 9'h1A0, 9'h1A0, 9'h180, 9'h100};
    opcode = SKZ;
    zero = z;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (phase !== PHASE_W'(p) || outs !== e[p]) begin
        errors++;
        $display("FAIL skz z%0b p%0d phase=%0d outs=%h required phase=%0d outs=%h", z, p, phase, outs, p, e[p]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_jmp();
    logic [7:0][8:0] e;
    e = {9'h008, 9'h008, 9'h000, 9'h004, 9'h1A0, 9'h1A0, 9'h180, 9'h100};
    opcode = JMP;
    zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (phase !== PHASE_W'(p) || outs !== e[p]) begin
        errors++;
        $display("FAIL jmp p%0d phase=%0d outs=%h required phase=%0d outs=%h", p, phase, outs, p, e[p]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_halt();
    logic [4:0][8:0] e;
    e = {9'h001, 9'h1A0, 9'h1A0, 9'h180, 9'h100};
    opcode = HLT;
    zero = 1'b0;
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (phase !== PHASE_W'(p) || outs !== e[p]) begin
        errors++;
        $display("FAIL hlt p%0d phase=%0d outs=%h required phase=%0d outs=%h", p, phase, outs, p, e[p]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (phase !== 4'd8 || outs !== 9'h001) begin
        errors++;
        $display("FAIL halted c%0d phase=%0d outs=%h required phase=8 outs=001", i, phase, outs);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phase !== 4'd0 || outs !== 9'h100) begin
      errors++;
      $display("FAIL async_reset phase=%0d outs=%h required phase=0 outs=100", phase, outs);
    end
    @(negedge clk);
    rst = 1'b1;
    opcode = LDA;
    @(negedge clk);
    checks++;
    if (phase !== 4'd1) begin
      errors++;
      $display("FAIL reset_release phase=%0d required 1", phase);
    end
  endtask
  initial begin
    test_reset();
    test_lda();
    test_sto();
    test_skz(1'b1);
    test_skz(1'b0);
    test_jmp();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Multi-cycle instruction sequencer for the Simple-RISC datapath.
- Steps a fixed 8-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register.
- Drives the load/enable strobes consumed by the datapath's registerNbits instances (IR, ACC, PC), plus memory read/write and bus-select controls.
- Sits directly upstream of those registers: its ld_* outputs feed their load inputs.

Parameters:
- PHASE_W, 4, width of phase state register (8 run phases + HALTED; must be >= 4)
- OPC_W, 3, opcode width; fixed encoding below, other values unsupported

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- opcode  input  OPC_W  IR opcode field; must be stable from IDLE through STORE
- zero  input  1  accumulator-is-zero flag from datapath
- sel  output  1  1 = address mux selects PC, 0 = IR operand field
- rd  output  1  memory read enable
- wr  output  1  memory write enable
- ld_ir  output  1  load strobe to instruction register
- ld_ac  output  1  load strobe to accumulator
- ld_pc  output  1  load strobe to PC (jump)
- inc_pc  output  1  PC increment strobe
- data_e  output  1  accumulator drives data bus
- halt  output  1  processor halted
- phase  output  PHASE_W  current phase, for debug/bench

Behaviour:
- Opcode encoding (shared package): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phases: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED=8.
- Normal sequence advances one phase per clock: 0->1->...->7->0, so every instruction takes 8 cycles.
- OP_ADDR with opcode==HLT: next phase is HALTED instead of OP_FETCH.
- HALTED holds indefinitely; only reset leaves it.
- Outputs are combinational decode of phase and opcode (plus zero). They update in the same cycle the phase changes; there are no registered outputs.
- Output decode per phase (any signal not listed is 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1. ld_ir is held across two phases so the IR captures stable data.
  - OP_ADDR: inc_pc=1 when opcode!=HLT; halt=1 when opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
  - HALTED: halt=1.
- Reset: rst=0 forces phase=INST_ADDR immediately, regardless of clock.
  - Outputs while in reset: sel=1, all others 0.
  - Reset asserted mid-instruction or in HALTED behaves the same way.
  - First rising edge after rst returns to 1 moves the controller to INST_FETCH.
- zero is sampled only in ALU_OP; its value in other phases has no effect.
- Invariant: at most one of ld_pc/inc_pc is asserted in any phase. A JMP with zero=1 still asserts only ld_pc.
- An undefined phase value (9..15) is decoded with all outputs 0 and returns to INST_ADDR on the next edge.

Decomposition:
- Package risc_pkg holds:
  - opcode localparams (HLT..JMP) and OPC_W;
  - phase localparams (INST_ADDR..HALTED) and PHASE_W.
- The package is shared with the datapath and bench.
- Single module, no sub-module: phase register plus combinational decode.
- Optional helper function is_aluop() in risc_pkg.

Test Plan:
- Reset/idle: rst=0 for 2 cycles then 1 -> during reset phase=0, sel=1, other outputs 0; after 8 edges phase wraps 7->0.
- LDA (opcode=5), zero=0 -> ld_ir=1 in phases 2-3; inc_pc=1 in phase 4; rd=1 in phases 5-7; ld_ac=1 only in phase 7; wr=0 throughout.
- STO (opcode=6) -> data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 and ld_ac=0 in phases 5-7.
- SKZ (opcode=1) run twice -> with zero=1, inc_pc=1 in phases 4 and 6; with zero=0, inc_pc=1 in phase 4 only.
- JMP (opcode=7), zero=1 -> ld_pc=1 in phases 6-7; inc_pc=0 in phase 6.
- HLT (opcode=0) -> in phase 4 halt=1, inc_pc=0; phase=8 for 20 further cycles with halt=1 and other outputs 0. Asserting rst=0 mid-cycle (not on an edge) drops phase to 0 and halt to 0 immediately.
